// File: rtl/muldiv_iter_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide,
// with a valid/ready handshake, flush, and RISC-V divide-by-zero/overflow results.
module muldiv_iter_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            KILL,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [2:0]      SELECT,
  output logic            RESULT_VALID,
  input  logic            RESULT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [2:0]        op;
  logic [XLEN-1:0]   d1;
  logic [XLEN-1:0]   d2;
  logic [XLEN-1:0]   opnd;
  logic [W2-1:0]     acc;
  logic [CNT_W-1:0]  cnt;
  logic              neg_res;

  logic              op1_signed, op2_signed, neg1, neg2;
  logic [XLEN-1:0]   abs1, abs2;
  logic              div_zero, ovf, special;
  logic [XLEN-1:0]   spec_val;
  logic              neg_calc;
  logic [XLEN:0]     add_sum;
  logic [W2-1:0]     mul_next;
  logic [XLEN:0]     srem;
  logic [XLEN-1:0]   diff;
  logic [W2-1:0]     div_next;
  logic [W2-1:0]     prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  // Operand conditioning and special-case detection for the PREP state
  always_comb begin
    op1_signed = op[2] ? !op[0] : (op[1] ^ op[0]);
    op2_signed = op[2] ? !op[0] : (op[1:0] == 2'b01);
    neg1       = op1_signed && d1[XLEN-1];
    neg2       = op2_signed && d2[XLEN-1];
    abs1       = neg1 ? (~d1 + XLEN'(1)) : d1;
    abs2       = neg2 ? (~d2 + XLEN'(1)) : d2;
    div_zero   = (d2 == '0);
    ovf        = op[2] && !op[0] && (d1 == MIN_NEG) && (d2 == '1);
    special    = op[2] && (div_zero || ovf);
    spec_val   = '0;
    if (div_zero) spec_val = op[1] ? d1 : '1;
    else if (ovf) spec_val = op[1] ? '0 : d1;
    neg_calc   = (op[2] && op[1]) ? neg1 : (neg1 ^ neg2);
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    add_sum  = {1'b0, acc[W2-1:XLEN]} + {1'b0, opnd};
    mul_next = acc[0] ? {add_sum, acc[XLEN-1:1]} : {1'b0, acc[W2-1:1]};
    // Shifted remainder needs one extra bit when the divisor exceeds 2^(XLEN-1)
    srem     = acc[W2-1:XLEN-1];
    diff     = srem[XLEN-1:0] - opnd;
    div_next = (srem >= {1'b0, opnd}) ? {diff, acc[XLEN-2:0], 1'b1}
                                      : {acc[W2-2:0], 1'b0};
  end

  // Sign fix-up and result selection
  always_comb begin
    prod_fix = neg_res ? (~acc + W2'(1)) : acc;
    quo_fix  = neg_res ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem_fix  = neg_res ? (~acc[W2-1:XLEN] + XLEN'(1)) : acc[W2-1:XLEN];
    case (op)
      3'b000:          fix_val = prod_fix[XLEN-1:0];
      3'b100, 3'b101:  fix_val = quo_fix;
      3'b110, 3'b111:  fix_val = rem_fix;
      default:         fix_val = prod_fix[W2-1:XLEN];
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      op           <= '0;
      d1           <= '0;
      d2           <= '0;
      opnd         <= '0;
      acc          <= '0;
      cnt          <= '0;
      neg_res      <= 1'b0;
      IN_READY     <= 1'b1;
      RESULT_VALID <= 1'b0;
      RESULT       <= '0;
      BUSY         <= 1'b0;
    end else if (KILL) begin
      state        <= S_IDLE;
      RESULT_VALID <= 1'b0;
      IN_READY     <= 1'b1;
      BUSY         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IN_VALID && IN_READY) begin
            op       <= SELECT;
            d1       <= DATA1;
            d2       <= DATA2;
            state    <= S_PREP;
            IN_READY <= 1'b0;
            BUSY     <= 1'b1;
          end
        end
        S_PREP: begin
          // Special divides skip CALC; both halves carry the answer so FIX
          // picks it up for either quotient or remainder selection.
          if (special) begin
            acc     <= {spec_val, spec_val};
            neg_res <= 1'b0;
            state   <= S_FIX;
          end else begin
            acc     <= {{XLEN{1'b0}}, (op[2] ? abs1 : abs2)};
            opnd    <= op[2] ? abs2 : abs1;
            neg_res <= neg_calc;
            cnt     <= CNT_W'(XLEN);
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          RESULT       <= fix_val;
          RESULT_VALID <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          if (RESULT_READY) begin
            RESULT_VALID <= 1'b0;
            IN_READY     <= 1'b1;
            BUSY         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit at XLEN = 32 with hand-computed results.
module tb_muldiv_iter_unit;

  logic        CLK = 1'b0;
  logic        RESET, KILL, IN_VALID, IN_READY, RESULT_VALID, RESULT_READY, BUSY;
  logic [31:0] DATA1, DATA2, RESULT;
  logic [2:0]  SELECT;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  muldiv_iter_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .KILL(KILL), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .RESULT_VALID(RESULT_VALID),
    .RESULT_READY(RESULT_READY), .RESULT(RESULT), .BUSY(BUSY)
  );

  localparam logic [2:0]  HI_SEL [3] = '{3'b001, 3'b011, 3'b010};
  localparam logic [31:0] HI_A   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] HI_B   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] HI_EXP [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

  localparam logic [2:0]  DV_SEL [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
  localparam logic [31:0] DV_A   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
  localparam logic [31:0] DV_B   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
  localparam logic [31:0] DV_EXP [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};

  localparam logic [2:0]  SP_SEL [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
  localparam logic [31:0] SP_A   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  localparam logic [31:0] SP_B   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] SP_EXP [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

  // Present one operation and hold it for exactly the accept edge
  task automatic accept(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    SELECT = sel; DATA1 = a; DATA2 = b; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    DATA1 = $urandom; DATA2 = $urandom; SELECT = 3'($urandom);
  endtask

  // Run one operation up to RESULT_VALID; lat counts edges after the accept edge
  task automatic do_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bad);
    accept(sel, a, b);
    lat = 0; bad = 0;
    while (RESULT_VALID !== 1'b1 && lat < 100) begin
      if (BUSY !== 1'b1 || IN_READY !== 1'b0) bad++;
      @(posedge CLK); #1;
      lat++;
    end
    res = RESULT;
  endtask

  task automatic take();
    @(negedge CLK);
    RESULT_READY = 1'b1;
    @(posedge CLK); #1;
    RESULT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", RESULT_VALID); end
    checks++; if (RESULT !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", RESULT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat, bad;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, bad);
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency: got %0d want 34", lat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mul_busy_ready: %0d cycles with BUSY low or IN_READY high, want 0", bad); end
    take();
  endtask

  task automatic test_mulh();
    logic [31:0] res; int lat, bad;
    for (int i = 0; i < 3; i++) begin
      do_op(HI_SEL[i], HI_A[i], HI_B[i], res, lat, bad);
      checks++; if (res !== HI_EXP[i]) begin errors++; $display("FAIL mulh_%0d: got %h want %h", i, res, HI_EXP[i]); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL mulh_lat_%0d: got %0d want 34", i, lat); end
      take();
    end
  endtask

  task automatic test_div();
    logic [31:0] res; int lat, bad;
    for (int i = 0; i < 4; i++) begin
      do_op(DV_SEL[i], DV_A[i], DV_B[i], res, lat, bad);
      checks++; if (res !== DV_EXP[i]) begin errors++; $display("FAIL div_%0d: got %h want %h", i, res, DV_EXP[i]); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL div_lat_%0d: got %0d want 34", i, lat); end
      take();
    end
  endtask

  task automatic test_special();
    logic [31:0] res; int lat, bad;
    for (int i = 0; i < 4; i++) begin
      do_op(SP_SEL[i], SP_A[i], SP_B[i], res, lat, bad);
      checks++; if (res !== SP_EXP[i]) begin errors++; $display("FAIL special_%0d: got %h want %h", i, res, SP_EXP[i]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL special_lat_%0d: got %0d want 2", i, lat); end
      take();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res; int lat, bad;
    do_op(3'b101, 32'd100, 32'd7, res, lat, bad);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL bp_result: got %h want 0000000e", res); end
    @(negedge CLK);
    IN_VALID = 1'b1; SELECT = 3'b000; DATA1 = 32'd3; DATA2 = 32'd3;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (RESULT !== 32'd14 || RESULT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got result=%h valid=%b ready=%b want 0000000e/1/0", c, RESULT, RESULT_VALID, IN_READY);
      end
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    take();
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", IN_READY); end
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b want 0", RESULT_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL bp_busy_after: got %b want 0", BUSY); end
    checks++; if (RESULT !== 32'd14) begin errors++; $display("FAIL bp_result_kept: got %h want 0000000e", RESULT); end
  endtask

  task automatic test_kill();
    logic seen;
    // KILL alongside IN_VALID in IDLE accepts nothing
    @(negedge CLK);
    KILL = 1'b1; IN_VALID = 1'b1; SELECT = 3'b000; DATA1 = 32'd2; DATA2 = 32'd2;
    @(posedge CLK); #1;
    KILL = 1'b0; IN_VALID = 1'b0;
    checks++; if (BUSY !== 1'b0 || IN_READY !== 1'b1) begin errors++; $display("FAIL kill_idle: got busy=%b ready=%b want 0/1", BUSY, IN_READY); end
    // KILL at CALC cycle 10 of a DIV
    accept(3'b100, 32'd1000, 32'd3);
    repeat (11) @(posedge CLK);
    @(negedge CLK);
    KILL = 1'b1;
    @(posedge CLK); #1;
    KILL = 1'b0;
    checks++; if (BUSY !== 1'b0 || IN_READY !== 1'b1 || RESULT_VALID !== 1'b0) begin
      errors++; $display("FAIL kill_calc: got busy=%b ready=%b valid=%b want 0/1/0", BUSY, IN_READY, RESULT_VALID);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (RESULT_VALID !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kill_no_valid: got valid seen=%b want 0", seen); end
    checks++; if (RESULT !== 32'd14) begin errors++; $display("FAIL kill_result_kept: got %h want 0000000e", RESULT); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int lat, bad;
    accept(3'b000, 32'd7, 32'd9);
    repeat (21) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    checks++; if (IN_READY !== 1'b1 || RESULT_VALID !== 1'b0 || RESULT !== 32'd0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got ready=%b valid=%b result=%h busy=%b want 1/0/0/0", IN_READY, RESULT_VALID, RESULT, BUSY);
    end
    @(negedge CLK);
    RESET = 1'b0;
    do_op(3'b011, 32'd3, 32'd5, res, lat, bad);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL post_reset_mulhu: got %h want 0", res); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL post_reset_lat: got %0d want 34", lat); end
    take();
  endtask

  initial begin
    RESET = 1'b1; KILL = 1'b0; IN_VALID = 1'b0; RESULT_READY = 1'b0;
    DATA1 = '0; DATA2 = '0; SELECT = '0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_backpressure();
    test_kill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
